// File: rtl/issue_queue_if.sv
// Issue queue bus: Rename push side, RF pop side, writeback wakeup broadcast
// and occupancy. The queue itself uses the slave modport.
interface issue_queue_if #(
  parameter int RENISS_WIDTH = 137,
  parameter int CNTW         = 4
);
  logic                    push_valid;
  logic [RENISS_WIDTH-1:0] push_data;
  logic                    IQ_stall_OUT;
  logic                    IQ_full_OUT;
  logic [RENISS_WIDTH-1:0] IQ_popData_OUT;
  logic                    IQ_LSQ_pop;
  logic                    write_register_flag;
  logic [5:0]              write_register_index;
  logic [CNTW-1:0]         count_OUT;

  modport master (
    output push_valid, push_data, IQ_LSQ_pop, write_register_flag, write_register_index,
    input  IQ_stall_OUT, IQ_full_OUT, IQ_popData_OUT, count_OUT
  );

  modport slave (
    input  push_valid, push_data, IQ_LSQ_pop, write_register_flag, write_register_index,
    output IQ_stall_OUT, IQ_full_OUT, IQ_popData_OUT, count_OUT
  );
endinterface

// File: rtl/issue_queue.sv
// Out-of-order issue queue: compacting age-ordered array (slot 0 oldest),
// oldest-ready select, writeback wakeup, one push and one pop per cycle.
// Optional feature macro IQ_PUSH_WAKEUP_EN: wake the sources of the entry
// being pushed against the writeback broadcast of the same cycle.
module issue_queue #(
  parameter int RENISS_WIDTH = 137,
  parameter int DEPTH        = 8,
  parameter int CNTW         = 4
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         FREEZE,
  input  logic         IQ_flush,
  issue_queue_if.slave iq
);
  localparam int S1P = 76;
  localparam int S1R = 82;
  localparam int S2P = 83;
  localparam int S2R = 89;

  typedef logic [RENISS_WIDTH-1:0] entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  entry_t          woke  [DEPTH];
  logic [CNTW-1:0] cnt_q, cnt_d, sel_idx, wr_idx;
  logic            sel_found, pop_acc, push_acc, stall;
  entry_t          sel_data, push_word;

  assign stall    = (cnt_q == CNTW'(DEPTH));
  assign pop_acc  = iq.IQ_LSQ_pop & sel_found & ~FREEZE;
  assign push_acc = iq.push_valid & ~stall & ~FREEZE;
  // A same-edge pop compacts the array, so the new entry lands one slot lower.
  assign wr_idx   = cnt_q - {{(CNTW-1){1'b0}}, pop_acc};

  assign iq.IQ_stall_OUT   = stall;
  assign iq.IQ_full_OUT    = sel_found;
  assign iq.IQ_popData_OUT = sel_data;
  assign iq.count_OUT      = cnt_q;

  // Select the oldest valid entry whose sources are both ready.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_data  = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (CNTW'(i) < cnt_q && mem_q[i][S1R] && mem_q[i][S2R]) begin
        sel_found = 1'b1;
        sel_idx   = CNTW'(i);
        sel_data  = mem_q[i];
      end
    end
  end

  // Entry written on push, optionally woken by the same-cycle broadcast.
  always_comb begin
    push_word = iq.push_data;
`ifdef IQ_PUSH_WAKEUP_EN
    if (iq.write_register_flag) begin
      if (iq.push_data[S1P +: 6] == iq.write_register_index) push_word[S1R] = 1'b1;
      if (iq.push_data[S2P +: 6] == iq.write_register_index) push_word[S2R] = 1'b1;
    end
`endif
  end

  // Wakeup of stored valid entries; invalid slots stay all-zero.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      woke[i] = mem_q[i];
      if (iq.write_register_flag && CNTW'(i) < cnt_q) begin
        if (mem_q[i][S1P +: 6] == iq.write_register_index) woke[i][S1R] = 1'b1;
        if (mem_q[i][S2P +: 6] == iq.write_register_index) woke[i][S2R] = 1'b1;
      end
    end
  end

  // Next array: compact over the popped slot, append push, flush wins.
  always_comb begin
    for (int i = 0; i < DEPTH-1; i++)
      mem_d[i] = (pop_acc && CNTW'(i) >= sel_idx) ? woke[i+1] : woke[i];
    mem_d[DEPTH-1] = pop_acc ? '0 : woke[DEPTH-1];
    for (int i = 0; i < DEPTH; i++)
      if (push_acc && CNTW'(i) == wr_idx) mem_d[i] = push_word;
    cnt_d = cnt_q + {{(CNTW-1){1'b0}}, push_acc} - {{(CNTW-1){1'b0}}, pop_acc};
    if (IQ_flush) begin
      for (int i = 0; i < DEPTH; i++) mem_d[i] = '0;
      cnt_d = '0;
    end
  end

  // State register; reset clears entries and count immediately.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end
endmodule

// File: tb/tb_issue_queue.sv
// Self-checking bench for issue_queue: directed vector table, hand-written
// corner sequences, then random traffic against a queue-based reference model.
module tb_issue_queue;
  localparam int W     = 137;
  localparam int DEPTH = 8;

  typedef logic [W-1:0] entry_t;

  typedef struct {
    logic   pv;
    entry_t pd;
    logic   pop;
    logic   wf;
    int     wi;
    logic   exp_full;
    int     exp_cnt;
    entry_t exp_data;
  } vec_t;

  logic CLK = 1'b0;
  logic RESET, FREEZE, IQ_flush;
  int   nvec = 0;
  int   nmis = 0;
  entry_t q[$];
  vec_t tbl[10];

  always #5 CLK = ~CLK;

  issue_queue_if #(.RENISS_WIDTH(W), .CNTW(4)) bus ();

  issue_queue #(.RENISS_WIDTH(W), .DEPTH(DEPTH), .CNTW(4)) dut (
    .CLK(CLK), .RESET(RESET), .FREEZE(FREEZE), .IQ_flush(IQ_flush), .iq(bus.slave)
  );

  function automatic entry_t mk(input int tag, input int s1, input int s1r, input int s2, input int s2r);
    entry_t r = '0;
    r[15:0]    = 16'(tag);
    r[136:120] = {1'b1, 16'(tag)};
    r[81:76]   = 6'(s1);
    r[82]      = s1r[0];
    r[88:83]   = 6'(s2);
    r[89]      = s2r[0];
    return r;
  endfunction

  function automatic vec_t v(input int pv, input entry_t pd, input int pop, input int wf, input int wi,
                             input int ef, input int ec, input entry_t ed);
    vec_t t;
    t.pv = pv[0]; t.pd = pd; t.pop = pop[0]; t.wf = wf[0]; t.wi = wi;
    t.exp_full = ef[0]; t.exp_cnt = ec; t.exp_data = ed;
    return t;
  endfunction

  function automatic logic rdy(input entry_t e);
    return e[82] & e[89];
  endfunction

  task automatic chk(input string nm, input entry_t act, input entry_t exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // Reference model: age-ordered list, oldest-ready pop, wakeup, append.
  task automatic model_step(input logic pv, input entry_t pd, input logic pop, input logic wf,
                            input int wi, input logic frz, input logic fl);
    int     sel = -1;
    logic   popa, pusha;
    entry_t d;
    if (fl) begin
      q.delete();
      return;
    end
    foreach (q[i]) if (sel < 0 && rdy(q[i])) sel = i;
    popa  = pop && sel >= 0 && !frz;
    pusha = pv && q.size() < DEPTH && !frz;
    if (wf) foreach (q[i]) begin
      if (int'(q[i][81:76]) == wi) q[i][82] = 1'b1;
      if (int'(q[i][88:83]) == wi) q[i][89] = 1'b1;
    end
    if (popa) q.delete(sel);
    if (pusha) begin
      d = pd;
`ifdef IQ_PUSH_WAKEUP_EN
      if (wf && int'(d[81:76]) == wi) d[82] = 1'b1;
      if (wf && int'(d[88:83]) == wi) d[89] = 1'b1;
`endif
      q.push_back(d);
    end
  endtask

  task automatic drive_edge(input logic pv, input entry_t pd, input logic pop, input logic wf,
                            input int wi, input logic frz, input logic fl);
    bus.push_valid           = pv;
    bus.push_data            = pd;
    bus.IQ_LSQ_pop           = pop;
    bus.write_register_flag  = wf;
    bus.write_register_index = 6'(wi);
    FREEZE                   = frz;
    IQ_flush                 = fl;
    @(posedge CLK);
    model_step(pv, pd, pop, wf, wi, frz, fl);
    #1;
    bus.push_valid = 1'b0; bus.IQ_LSQ_pop = 1'b0; bus.write_register_flag = 1'b0;
    FREEZE = 1'b0; IQ_flush = 1'b0;
  endtask

  task automatic idle(); drive_edge(1'b0, '0, 1'b0, 1'b0, 0, 1'b0, 1'b0); endtask
  task automatic push(input entry_t e); drive_edge(1'b1, e, 1'b0, 1'b0, 0, 1'b0, 1'b0); endtask
  task automatic wake(input int p); drive_edge(1'b0, '0, 1'b0, 1'b1, p, 1'b0, 1'b0); endtask
  task automatic pop1(); drive_edge(1'b0, '0, 1'b1, 1'b0, 0, 1'b0, 1'b0); endtask

  task automatic check_model(input string nm);
    entry_t ed = '0;
    logic   ef = 1'b0;
    foreach (q[i]) if (!ef && rdy(q[i])) begin ef = 1'b1; ed = q[i]; end
    chk({nm, ".full"},  W'(bus.IQ_full_OUT),  W'(ef));
    chk({nm, ".count"}, W'(bus.count_OUT),    W'(q.size()));
    chk({nm, ".stall"}, W'(bus.IQ_stall_OUT), W'(q.size() == DEPTH));
    chk({nm, ".data"},  bus.IQ_popData_OUT,   ed);
  endtask

  task automatic check_zero(input string nm);
    chk({nm, ".full"},  W'(bus.IQ_full_OUT),  '0);
    chk({nm, ".count"}, W'(bus.count_OUT),    '0);
    chk({nm, ".stall"}, W'(bus.IQ_stall_OUT), '0);
    chk({nm, ".data"},  bus.IQ_popData_OUT,   '0);
  endtask

  initial begin
    int     order[7];
    entry_t rd;
    RESET = 1'b0; FREEZE = 1'b0; IQ_flush = 1'b0;
    bus.push_valid = 1'b0; bus.push_data = '0; bus.IQ_LSQ_pop = 1'b0;
    bus.write_register_flag = 1'b0; bus.write_register_index = '0;

    // Reset state
    #3 check_zero("reset");
    #9 RESET = 1'b1;

    // Directed table: expected outputs after each edge
    tbl[0] = v(1, mk(1, 5, 1, 6, 1), 0, 0, 0,  1, 1, mk(1, 5, 1, 6, 1));
    tbl[1] = v(0, '0,                1, 0, 0,  0, 0, '0);
    tbl[2] = v(1, mk(2, 3, 0, 7, 1), 0, 0, 0,  0, 1, '0);
    tbl[3] = v(1, mk(3, 8, 1, 9, 1), 0, 0, 0,  1, 2, mk(3, 8, 1, 9, 1));
    tbl[4] = v(0, '0,                1, 1, 3,  1, 1, mk(2, 3, 1, 7, 1));
    tbl[5] = v(0, '0,                1, 0, 0,  0, 0, '0);
    tbl[6] = v(1, mk(4, 10, 1, 11, 0), 0, 0, 0, 0, 1, '0);
    tbl[7] = v(0, '0,                0, 1, 10, 0, 1, '0);
    tbl[8] = v(0, '0,                0, 1, 11, 1, 1, mk(4, 10, 1, 11, 1));
    tbl[9] = v(0, '0,                1, 0, 0,  0, 0, '0);
    for (int k = 0; k < 10; k++) begin
      drive_edge(tbl[k].pv, tbl[k].pd, tbl[k].pop, tbl[k].wf, tbl[k].wi, 1'b0, 1'b0);
      chk($sformatf("tbl%0d.full", k),  W'(bus.IQ_full_OUT), W'(tbl[k].exp_full));
      chk($sformatf("tbl%0d.count", k), W'(bus.count_OUT),   W'(tbl[k].exp_cnt));
      chk($sformatf("tbl%0d.data", k),  bus.IQ_popData_OUT,  tbl[k].exp_data);
    end

    // Fill with not-ready entries, then full + push + pop of slot 2 + wakeup
    for (int i = 0; i < DEPTH; i++) push(mk(10 + i, 20 + i, 0, 40, 1));
    chk("fill.stall", W'(bus.IQ_stall_OUT), W'(1));
    chk("fill.count", W'(bus.count_OUT), W'(8));
    wake(22);
    check_model("wake22");
    drive_edge(1'b1, mk(99, 1, 1, 1, 1), 1'b1, 1'b1, 23, 1'b0, 1'b0);
    chk("full9.count", W'(bus.count_OUT), W'(7));
    chk("full9.stall", W'(bus.IQ_stall_OUT), W'(0));
    chk("full9.tag",   W'(bus.IQ_popData_OUT[15:0]), W'(13));
    chk("full9.s1rdy", W'(bus.IQ_popData_OUT[82]), W'(1));
    check_model("full9");
    wake(20); wake(21); wake(24); wake(25); wake(26); wake(27);
    order = '{10, 11, 13, 14, 15, 16, 17};
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("order%0d", k), W'(bus.IQ_popData_OUT[15:0]), W'(order[k]));
      pop1();
    end
    chk("drain.count", W'(bus.count_OUT), W'(0));

    // FREEZE blocks push/pop but not wakeup
    push(mk(30, 9, 0, 41, 1));
    drive_edge(1'b1, mk(31, 1, 1, 2, 1), 1'b1, 1'b1, 9, 1'b1, 1'b0);
    chk("frz.count", W'(bus.count_OUT), W'(1));
    chk("frz.full",  W'(bus.IQ_full_OUT), W'(1));
    chk("frz.tag",   W'(bus.IQ_popData_OUT[15:0]), W'(30));
    drive_edge(1'b0, '0, 1'b1, 1'b0, 0, 1'b1, 1'b0);
    chk("frz2.count", W'(bus.count_OUT), W'(1));
    pop1();
    chk("unfrz.count", W'(bus.count_OUT), W'(0));

    // Same-cycle broadcast on push
    drive_edge(1'b1, mk(40, 1, 1, 12, 0), 1'b0, 1'b1, 12, 1'b0, 1'b0);
    chk("pushwake.count", W'(bus.count_OUT), W'(1));
`ifdef IQ_PUSH_WAKEUP_EN
    chk("pushwake.full", W'(bus.IQ_full_OUT), W'(1));
`else
    chk("pushwake.full", W'(bus.IQ_full_OUT), W'(0));
`endif
    drive_edge(1'b0, '0, 1'b0, 1'b0, 0, 1'b0, 1'b1);

    // Flush beats a simultaneous push
    for (int i = 0; i < 5; i++) push(mk(50 + i, 2, 1, 3, 1));
    chk("preflush.count", W'(bus.count_OUT), W'(5));
    drive_edge(1'b1, mk(60, 2, 1, 3, 1), 1'b0, 1'b0, 0, 1'b0, 1'b1);
    check_zero("flush");
    idle();
    check_zero("postflush");

    // Asynchronous reset mid-cycle
    push(mk(70, 2, 1, 3, 1));
    push(mk(71, 2, 1, 3, 1));
    chk("prerst.count", W'(bus.count_OUT), W'(2));
    #2 RESET = 1'b0;
    q.delete();
    #1 check_zero("midrst");
    @(negedge CLK) RESET = 1'b1;

    // Random traffic against the reference model
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < W; b++) rd[b] = 1'($urandom_range(0, 1));
      rd[81:76] = 6'($urandom_range(0, 7));
      rd[88:83] = 6'($urandom_range(0, 7));
      drive_edge(1'($urandom_range(0, 99) < 60), rd,
                 1'($urandom_range(0, 99) < 45),
                 1'($urandom_range(0, 99) < 50), $urandom_range(0, 7),
                 1'($urandom_range(0, 99) < 10),
                 1'($urandom_range(0, 99) < 2));
      check_model($sformatf("rnd%0d", c));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
